// File: rtl/ps2host_tx_if.sv
// PS/2 transmit request bundle between a command source and ps2host_tx.
// master: drives tx_data/tx_start; slave: returns tx_busy/tx_done/tx_err.
interface ps2host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output tx_data,
        output tx_start,
        input  tx_busy,
        input  tx_done,
        input  tx_err
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output tx_busy,
        output tx_done,
        output tx_err
    );
endinterface

// File: rtl/ps2host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits
// LSB first, odd parity, stop, device ACK; runs on the dot clock.
// Ports: clk, rstn_i (async active-low), tx (ps2host_tx_if.slave:
//   tx_data, tx_start, tx_busy, tx_done, tx_err), ps2c_i/ps2d_i line
//   levels, ps2c_oe/ps2d_oe active-high pull-low enables.
// Option: define PS2TX_ACK_CHECK_EN to report a missing device ACK
//   through tx_err; otherwise only a timeout sets tx_err.
module ps2host_tx #(
    parameter int INHIBIT_CYCLES = 800,
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic        clk,
    input  logic        rstn_i,
    ps2host_tx_if.slave tx,
    input  logic        ps2c_i,
    input  logic        ps2d_i,
    output logic        ps2c_oe,
    output logic        ps2d_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAITREL,
        S_DONE
    } state_t;

    state_t           state;
    logic [1:0]       c_sync;
    logic [1:0]       d_sync;
    logic             c_prev;
    logic             c_fall;
    logic [9:0]       shreg;
    logic [3:0]       bit_n;
    logic [INH_W-1:0] inh_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             to_hit;
    logic             ack_bad;
    logic             watched;

    // Synchronisers idle high so reset release never fakes a falling edge.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
            c_prev <= 1'b1;
        end else begin
            c_sync <= {c_sync[0], ps2c_i};
            d_sync <= {d_sync[0], ps2d_i};
            c_prev <= c_sync[1];
        end
    end

    assign c_fall  = c_prev & ~c_sync[1];
    assign to_hit  = (to_cnt == TO_LAST);
    assign watched = (state == S_SEND) || (state == S_ACK)
                   || (state == S_WAITREL);

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bit_n      <= '0;
            inh_cnt    <= '0;
            to_cnt     <= '0;
            ack_bad    <= 1'b0;
            ps2c_oe    <= 1'b0;
            ps2d_oe    <= 1'b0;
            tx.tx_busy <= 1'b0;
            tx.tx_done <= 1'b0;
            tx.tx_err  <= 1'b0;
        end else if (watched && to_hit) begin
            // Timeout beats a coincident falling edge.
            ps2c_oe   <= 1'b0;
            ps2d_oe   <= 1'b0;
            tx.tx_done <= 1'b1;
            tx.tx_err  <= 1'b1;
            state     <= S_DONE;
        end else begin
            if (watched) begin
                if (c_fall) begin
                    to_cnt <= '0;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    if (tx.tx_start) begin
                        // Frame tail after the start bit: data, parity, stop.
                        shreg      <= {1'b1, ~^tx.tx_data, tx.tx_data};
                        inh_cnt    <= '0;
                        ps2c_oe    <= 1'b1;
                        tx.tx_busy <= 1'b1;
                        state      <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        ps2d_oe <= 1'b1;
                        state   <= S_REQ;
                    end else begin
                        inh_cnt <= inh_cnt + INH_W'(1);
                    end
                end

                S_REQ: begin
                    // Data stays low: that is the start bit.
                    ps2c_oe <= 1'b0;
                    to_cnt  <= '0;
                    bit_n   <= '0;
                    state   <= S_SEND;
                end

                S_SEND: begin
                    if (c_fall) begin
                        if (bit_n == 4'd10) begin
                            state <= S_ACK;
                        end else begin
                            bit_n   <= bit_n + 4'd1;
                            ps2d_oe <= ~shreg[0];
                            shreg   <= {1'b0, shreg[9:1]};
                        end
                    end
                end

                S_ACK: begin
`ifdef PS2TX_ACK_CHECK_EN
                    ack_bad <= d_sync[1];
`else
                    ack_bad <= 1'b0;
`endif
                    state <= S_WAITREL;
                end

                S_WAITREL: begin
                    if (c_sync[1] && d_sync[1]) begin
                        tx.tx_done <= 1'b1;
                        tx.tx_err  <= ack_bad;
                        state      <= S_DONE;
                    end
                end

                S_DONE: begin
                    tx.tx_done <= 1'b0;
                    tx.tx_err  <= 1'b0;
                    tx.tx_busy <= 1'b0;
                    ack_bad    <= 1'b0;
                    state      <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2host_tx.sv
// Bench for ps2host_tx: PS/2 device model, vector table of frames,
// plus hand sequences for timeout, mid-frame reset and ignored starts.
module tb_ps2host_tx;

    localparam int INH = 800;
    localparam int TO  = 3000;
    localparam int H   = 20;

`ifdef PS2TX_ACK_CHECK_EN
    localparam bit ACK_CHK = 1'b1;
`else
    localparam bit ACK_CHK = 1'b0;
`endif

    typedef struct {
        logic [7:0]  data;
        bit          ack;
        int          nfall;
        bit          poke;
        bit          sid;
        bit          exp_err;
        logic [10:0] exp_frame;
    } vec_t;

    logic clk = 1'b0;
    logic rstn_i;
    logic ps2c_i;
    logic ps2d_i;
    logic ps2c_oe;
    logic ps2d_oe;
    logic dev_c;
    logic dev_d;
    bit   abort;
    int   dev_falls;
    int   t_fall;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ps2host_tx_if bus ();

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ps2c_i = dev_c & ~ps2c_oe;
    assign ps2d_i = dev_d & ~ps2d_oe;

    ps2host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk    (clk),
        .rstn_i (rstn_i),
        .tx     (bus),
        .ps2c_i (ps2c_i),
        .ps2d_i (ps2d_i),
        .ps2c_oe(ps2c_oe),
        .ps2d_oe(ps2d_oe)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic dev_run(input int nfall, input bit ack,
                           output logic [10:0] bits);
        bit got;
        got  = 1'b0;
        bits = '0;
        for (int i = 0; i < 3000 && !got && !abort; i++) begin
            @(negedge clk);
            if (ps2d_oe && !ps2c_oe) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL dev_req: request not seen, expected one");
        end else begin
            repeat (10) @(negedge clk);
            for (int k = 0; k < 11; k++) begin
                if (k >= nfall || abort) break;
                repeat (H) @(negedge clk);
                bits[k] = ps2d_i;
                if (k == 10) begin
                    if (ack) dev_d = 1'b0;
                    repeat (2) @(negedge clk);
                end
                dev_c = 1'b0;
                t_fall = cyc;
                dev_falls++;
                repeat (H) @(negedge clk);
                dev_c = 1'b1;
            end
            repeat (H) @(negedge clk);
            dev_d = 1'b1;
        end
    endtask

    task automatic mon_run(input bit poke, input bit sid,
                           output bit seen, output bit err,
                           output bit oe_d, output int inh,
                           output int gap, output int tdone,
                           output bit busy_after);
        bit poked;
        poked = 1'b0;
        seen = 1'b0; err = 1'b0; oe_d = 1'b0;
        inh = 0; gap = 0; tdone = 0;
        for (int i = 0; i < 20000; i++) begin
            if (!bus.tx_busy) gap++;
            if (ps2c_oe && !ps2d_oe) inh++;
            bus.tx_start = 1'b0;
            if (poke && !poked && dev_falls == 6) begin
                bus.tx_data  = 8'h00;
                bus.tx_start = 1'b1;
                poked = 1'b1;
            end
            if (bus.tx_done) begin
                seen  = 1'b1;
                err   = bus.tx_err;
                oe_d  = ps2c_oe | ps2d_oe;
                tdone = cyc;
                if (sid) bus.tx_start = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.tx_start = 1'b0;
        busy_after = bus.tx_busy;
    endtask

    task automatic xfer(input vec_t v, input int idx);
        logic [10:0] bits;
        logic [11:0] m12;
        bit   seen, err, oe_d, busy_after, moved;
        int   inh, gap, tdone, delta;
        dev_falls = 0;
        @(negedge clk);
        bus.tx_data  = v.data;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        fork
            dev_run(v.nfall, v.ack, bits);
            mon_run(v.poke, v.sid, seen, err, oe_d, inh, gap, tdone,
                    busy_after);
        join
        m12 = (12'd1 << v.nfall) - 12'd1;
        $display("vector %0d data %02h", idx, v.data);
        chk("done", 32'(seen), 32'(1));
        chk("err", 32'(err), 32'(v.exp_err));
        chk("frame", 32'(bits & m12[10:0]),
            32'(v.exp_frame & m12[10:0]));
        chk("inhibit_len", 32'(inh), 32'(INH));
        chk("busy_gap", 32'(gap), 32'(0));
        chk("oe_at_done", 32'(oe_d), 32'(0));
        chk("busy_after", 32'(busy_after), 32'(0));
        if (v.nfall < 11) begin
            delta = tdone - t_fall;
            chk("to_window", 32'(delta >= TO && delta <= TO + 5),
                32'(1));
        end
        moved = 1'b0;
        repeat (900) begin
            @(negedge clk);
            if (ps2c_oe || ps2d_oe || bus.tx_busy) moved = 1'b1;
        end
        chk("stays_idle", 32'(moved), 32'(0));
    endtask

    initial begin
        vec_t        vt[6];
        vec_t        vff;
        logic [10:0] bits_r;

        vt[0] = '{8'hED, 1'b1, 11, 1'b0, 1'b0, 1'b0, 11'b1_1_11101101_0};
        vt[1] = '{8'hF4, 1'b1, 11, 1'b0, 1'b1, 1'b0, 11'b1_0_11110100_0};
        vt[2] = '{8'h3C, 1'b1, 11, 1'b1, 1'b0, 1'b0, 11'b1_1_00111100_0};
        vt[3] = '{8'hED, 1'b0, 11, 1'b0, 1'b0, ACK_CHK,
                  11'b1_1_11101101_0};
        vt[4] = '{8'hF4, 1'b1, 4,  1'b0, 1'b0, 1'b1, 11'b1_0_11110100_0};
        vt[5] = '{8'h00, 1'b1, 11, 1'b0, 1'b0, 1'b0, 11'b1_1_00000000_0};
        vff   = '{8'hFF, 1'b1, 11, 1'b0, 1'b0, 1'b0, 11'b1_1_11111111_0};

        rstn_i       = 1'b0;
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        dev_c        = 1'b1;
        dev_d        = 1'b1;
        abort        = 1'b0;
        dev_falls    = 0;
        t_fall       = 0;

        repeat (3) @(negedge clk);
        chk("rst_c_oe", 32'(ps2c_oe), 32'(0));
        chk("rst_d_oe", 32'(ps2d_oe), 32'(0));
        chk("rst_busy", 32'(bus.tx_busy), 32'(0));
        chk("rst_done", 32'(bus.tx_done), 32'(0));
        chk("rst_err", 32'(bus.tx_err), 32'(0));
        rstn_i = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            xfer(vt[i], i);
        end

        dev_falls = 0;
        abort     = 1'b0;
        fork
            dev_run(11, 1'b1, bits_r);
            begin
                @(negedge clk);
                bus.tx_data  = 8'hA5;
                bus.tx_start = 1'b1;
                @(negedge clk);
                bus.tx_start = 1'b0;
                for (int i = 0; i < 5000 && dev_falls < 5; i++)
                    @(negedge clk);
                chk("rst_reach_bit5", 32'(dev_falls >= 5), 32'(1));
                repeat (5) @(negedge clk);
                chk("pre_rst_d_oe", 32'(ps2d_oe), 32'(1));
                #2 rstn_i = 1'b0;
                #1;
                chk("midrst_c_oe", 32'(ps2c_oe), 32'(0));
                chk("midrst_d_oe", 32'(ps2d_oe), 32'(0));
                chk("midrst_busy", 32'(bus.tx_busy), 32'(0));
                abort = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        dev_c  = 1'b1;
        dev_d  = 1'b1;
        abort  = 1'b0;
        rstn_i = 1'b1;
        repeat (5) @(negedge clk);
        xfer(vff, 6);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
